shift_chain_controller: RTL and testbench



---
 rtl/shift_chain_controller.sv | 189 ++++++++++++++++++
 tb/tb_shift_chain_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_controller.sv
// Shares a daisy-chain of 9-bit serial-to-parallel stages between two requesters:
// round-robin arbitration, divided shift clock, one pad bit per stage, output blanking.
module shift_chain_controller #(
  parameter int CHAIN_LEN = 2,
  parameter int DIV       = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req0_valid,
  input  logic [8*CHAIN_LEN-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [8*CHAIN_LEN-1:0] req1_data,
  output logic                   req1_ready,
  output logic                   sr_clock,
  output logic                   sr_data,
  output logic                   sr_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   grant_id,
  output logic [1:0]             state_dbg
);

  localparam int NBITS = 9 * CHAIN_LEN;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(NBITS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               last_q, last_d;
  logic               sr_clock_q, sr_clock_d;
  logic               sr_data_q, sr_data_d;
  logic               sr_oe_q, sr_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               grant_id_q, grant_id_d;

  logic               grant0, grant1, accept, accept_id;
  logic               div_end, bit_end;
  logic [NBITS-1:0]   accept_frame;

  // Stage k occupies frame bits [9k+8:9k] with its pad bit on top, so sending
  // the frame MSB first lands the farthest stage's pad bit deepest in the chain.
  function automatic logic [NBITS-1:0] pad_frame(input logic [8*CHAIN_LEN-1:0] d);
    logic [NBITS-1:0] p;
    p = '0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      p[9*k +: 9] = {1'b0, d[8*k +: 8]};
    end
    return p;
  endfunction

  // Handshake: a frame transfers on a rising clock edge where valid and ready
  // are both high. Ready is only offered in IDLE, to at most one requester; a
  // requester holds valid and data stable until ready, and may withdraw valid.
  // last_q holds the id granted last; both valid -> the other one wins.
  always_comb begin
    grant0       = req0_valid & (~req1_valid | last_q);
    grant1       = req1_valid & (~req0_valid | ~last_q);
    req0_ready   = (state_q == ST_IDLE) & grant0;
    req1_ready   = (state_q == ST_IDLE) & grant1;
    accept       = req0_ready | req1_ready;
    accept_id    = req1_ready;
    accept_frame = pad_frame(req1_ready ? req1_data : req0_data);
    div_end      = (div_q == DIV_W'(DIV - 1));
    bit_end      = (bit_q == BIT_W'(NBITS - 1));
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_end) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (div_end) state_d = bit_end ? ST_DONE : ST_SHIFT_LO;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every chain-facing output is registered
  always_comb begin
    frame_d    = frame_q;
    div_d      = div_q;
    bit_d      = bit_q;
    last_d     = last_q;
    sr_clock_d = sr_clock_q;
    sr_data_d  = sr_data_q;
    sr_oe_d    = sr_oe_q;
    grant_id_d = grant_id_q;
    done_d     = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d    = accept_frame;
          sr_data_d  = accept_frame[NBITS-1];
          sr_clock_d = 1'b0;
          sr_oe_d    = 1'b0;
          grant_id_d = accept_id;
          last_d     = accept_id;
          div_d      = '0;
          bit_d      = '0;
        end
      end
      ST_SHIFT_LO: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) sr_clock_d = 1'b1;
      end
      ST_SHIFT_HI: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sr_clock_d = 1'b0;
          if (bit_end) begin
            done_d  = 1'b1;
            sr_oe_d = 1'b1;
          end else begin
            // Data advances together with the falling shift clock only.
            bit_d     = bit_q + 1'b1;
            frame_d   = {frame_q[NBITS-2:0], frame_q[NBITS-1]};
            sr_data_d = frame_q[NBITS-2];
          end
        end
      end
      ST_DONE: begin
        sr_clock_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q    <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      last_q     <= 1'b1;
      sr_clock_q <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      grant_id_q <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      sr_clock_q <= sr_clock_d;
      sr_data_q  <= sr_data_d;
      sr_oe_q    <= sr_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign sr_clock  = sr_clock_q;
  assign sr_data   = sr_data_q;
  assign sr_oe     = sr_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign grant_id  = grant_id_q;
  assign state_dbg = state_q;

  ap_one_ready: assert property (@(posedge clock) disable iff (!reset_n)
    !(req0_ready && req1_ready));
  ap_oe_low_shifting: assert property (@(posedge clock) disable iff (!reset_n)
    (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI) |-> !sr_oe_q);

endmodule

// File: tb/tb_shift_chain_controller.sv
// Directed bench for shift_chain_controller: a CHAIN_LEN=2/DIV=4 instance with a
// two-stage chain model, plus a CHAIN_LEN=1/DIV=1 instance.
module tb_shift_chain_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: CHAIN_LEN=2, DIV=4 ----------------
  logic        a_r0_valid = 1'b0, a_r1_valid = 1'b0;
  logic [15:0] a_r0_data = '0, a_r1_data = '0;
  logic        a_r0_ready, a_r1_ready;
  logic        a_sr_clock, a_sr_data, a_sr_oe, a_busy, a_done, a_gid;
  logic [1:0]  a_state;

  shift_chain_controller #(.CHAIN_LEN(2), .DIV(4)) u_a (
    .clock(clk), .reset_n(rst_n),
    .req0_valid(a_r0_valid), .req0_data(a_r0_data), .req0_ready(a_r0_ready),
    .req1_valid(a_r1_valid), .req1_data(a_r1_data), .req1_ready(a_r1_ready),
    .sr_clock(a_sr_clock), .sr_data(a_sr_data), .sr_oe(a_sr_oe),
    .busy(a_busy), .done(a_done), .grant_id(a_gid), .state_dbg(a_state)
  );

  // ---------------- DUT B: CHAIN_LEN=1, DIV=1 ----------------
  logic       b_r0_valid = 1'b0, b_r1_valid = 1'b0;
  logic [7:0] b_r0_data = '0, b_r1_data = '0;
  logic       b_r0_ready, b_r1_ready;
  logic       b_sr_clock, b_sr_data, b_sr_oe, b_busy, b_done, b_gid;
  logic [1:0] b_state;

  shift_chain_controller #(.CHAIN_LEN(1), .DIV(1)) u_b (
    .clock(clk), .reset_n(rst_n),
    .req0_valid(b_r0_valid), .req0_data(b_r0_data), .req0_ready(b_r0_ready),
    .req1_valid(b_r1_valid), .req1_data(b_r1_data), .req1_ready(b_r1_ready),
    .sr_clock(b_sr_clock), .sr_data(b_sr_data), .sr_oe(b_sr_oe),
    .busy(b_busy), .done(b_done), .grant_id(b_gid), .state_dbg(b_state)
  );

  // ---------------- check ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- chain models (two 9-bit stages / one 9-bit stage) ----------------
  logic [17:0] a_chain = '0;
  int          a_rises = 0;
  always @(posedge a_sr_clock) begin
    a_chain <= {a_chain[16:0], a_sr_data};
    a_rises <= a_rises + 1;
  end

  logic [8:0] b_chain = '0;
  int         b_rises = 0;
  always @(posedge b_sr_clock) begin
    b_chain <= {b_chain[7:0], b_sr_data};
    b_rises <= b_rises + 1;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        gid_q[$];
  logic [15:0] drv0_q[$];
  logic [15:0] drv1_q[$];
  int          b2b_first = 1000000;

  int   cyc_n = 0, acc_cyc = 0, done_cyc = 0, acc_cnt = 0;
  int   rises_at_acc = 0, oe_bad = 0, data_bad = 0, both_cnt = 0;
  logic prev_sd = 1'b0;
  logic exp_id_cur = 1'b0;
  logic [15:0] exp_frame;

  always @(negedge clk) begin
    cyc_n++;
    if (rst_n) begin
      if (a_r0_ready && a_r1_ready) both_cnt++;
      if (a_busy && !a_done && a_sr_oe) oe_bad++;
      if (a_sr_clock && (a_sr_data !== prev_sd)) data_bad++;
      if ((a_r0_valid && a_r0_ready) || (a_r1_valid && a_r1_ready)) begin
        acc_cnt++;
        if (gid_q.size() == 0) begin
          check("grant_unexpected", 32'd1, 32'd0);
        end else begin
          exp_id_cur = gid_q.pop_front();
          check("grant_order", {31'd0, a_r1_ready}, {31'd0, exp_id_cur});
        end
        if (acc_cnt > b2b_first) check("b2b_gap", cyc_n - done_cyc, 32'd1);
        acc_cyc      = cyc_n;
        rises_at_acc = a_rises;
        oe_bad       = 0;
        data_bad     = 0;
      end
      if (a_done) begin
        check("done_latency", cyc_n - acc_cyc, 32'd145);
        check("sr_clock_rises", a_rises - rises_at_acc, 32'd18);
        check("oe_low_while_shifting", oe_bad, 32'd0);
        check("data_stable_clk_high", data_bad, 32'd0);
        check("sr_oe_at_done", {31'd0, a_sr_oe}, 32'd1);
        check("grant_id_at_done", {31'd0, a_gid}, {31'd0, exp_id_cur});
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_frame = exp_q.pop_front();
          check("stage0", {24'd0, a_chain[7:0]}, {24'd0, exp_frame[7:0]});
          check("stage1", {24'd0, a_chain[16:9]}, {24'd0, exp_frame[15:8]});
          check("pads", {30'd0, a_chain[17], a_chain[8]}, 32'd0);
        end
        done_cyc = cyc_n;
      end
    end
    prev_sd = a_sr_data;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_step();
    @(negedge clk);
    if (a_r0_valid && a_r0_ready) void'(drv0_q.pop_front());
    if (a_r1_valid && a_r1_ready) void'(drv1_q.pop_front());
    @(posedge clk);
    #1;
    a_r0_valid = (drv0_q.size() != 0);
    a_r0_data  = a_r0_valid ? drv0_q[0] : 16'h0;
    a_r1_valid = (drv1_q.size() != 0);
    a_r1_data  = a_r1_valid ? drv1_q[0] : 16'h0;
  endtask

  task automatic present();
    a_r0_valid = (drv0_q.size() != 0);
    a_r0_data  = a_r0_valid ? drv0_q[0] : 16'h0;
    a_r1_valid = (drv1_q.size() != 0);
    a_r1_data  = a_r1_valid ? drv1_q[0] : 16'h0;
  endtask

  task automatic drive_until_empty(input int budget);
    int n;
    n = 0;
    present();
    while ((drv0_q.size() != 0 || drv1_q.size() != 0 || a_busy) && n < budget) begin
      drive_step();
      n++;
    end
    if (n >= budget) check("timeout_drive", 32'd1, 32'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, r0;
    logic prev_clk;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sr_clock", {31'd0, a_sr_clock}, 32'd0);
    check("rst_sr_oe",    {31'd0, a_sr_oe},    32'd0);
    check("rst_busy",     {31'd0, a_busy},     32'd0);
    check("rst_done",     {31'd0, a_done},     32'd0);
    check("rst_state",    {30'd0, a_state},    32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single req0 frame A55A
    drv0_q.push_back(16'hA55A); exp_q.push_back(16'hA55A); gid_q.push_back(1'b0);
    drive_until_empty(400);
    repeat (3) @(negedge clk);
    check("oe_held_idle", {31'd0, a_sr_oe}, 32'd1);
    check("idle_busy",    {31'd0, a_busy},  32'd0);

    // 2: both valid from reset, 1234 / FEDC
    reset_pulse();
    drv0_q.push_back(16'h1234); drv1_q.push_back(16'hFEDC);
    exp_q.push_back(16'h1234);  exp_q.push_back(16'hFEDC);
    gid_q.push_back(1'b0);      gid_q.push_back(1'b1);
    present();
    b2b_first = acc_cnt + 1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_until_empty(800);

    // 3: req1 alone, three back-to-back frames
    b2b_first = acc_cnt + 1;
    drv1_q.push_back(16'h0001); drv1_q.push_back(16'h8000); drv1_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0001);  exp_q.push_back(16'h8000);  exp_q.push_back(16'hFFFF);
    repeat (3) gid_q.push_back(1'b1);
    drive_until_empty(1000);

    // 4: both continuously valid for four frames
    b2b_first = acc_cnt + 1;
    drv0_q.push_back(16'h0F0F); drv0_q.push_back(16'h3C3C);
    drv1_q.push_back(16'h1111); drv1_q.push_back(16'h2222);
    exp_q.push_back(16'h0F0F); exp_q.push_back(16'h1111);
    exp_q.push_back(16'h3C3C); exp_q.push_back(16'h2222);
    gid_q.push_back(1'b0); gid_q.push_back(1'b1);
    gid_q.push_back(1'b0); gid_q.push_back(1'b1);
    drive_until_empty(1200);

    // 5: reset while bit 7 of a req1 frame is on the wire
    b2b_first = 1000000;
    drv1_q.push_back(16'h1357); gid_q.push_back(1'b1);
    present();
    n = 0;
    while (drv1_q.size() != 0 && n < 20) begin
      drive_step();
      n++;
    end
    r0 = rises_at_acc;
    n = 0;
    while ((a_rises - r0) < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("timeout_bit7", 32'd1, 32'd0);
    check("pre_rst_busy",    {31'd0, a_busy},     32'd1);
    check("pre_rst_sr_data", {31'd0, a_sr_data},  32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sr_clock", {31'd0, a_sr_clock}, 32'd0);
    check("abort_sr_data",  {31'd0, a_sr_data},  32'd0);
    check("abort_sr_oe",    {31'd0, a_sr_oe},    32'd0);
    check("abort_busy",     {31'd0, a_busy},     32'd0);
    check("abort_done",     {31'd0, a_done},     32'd0);
    check("abort_grant_id", {31'd0, a_gid},      32'd0);
    check("abort_state",    {30'd0, a_state},    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drv0_q.push_back(16'h00FF); exp_q.push_back(16'h00FF); gid_q.push_back(1'b0);
    drive_until_empty(400);

    // 6: DIV=1, CHAIN_LEN=1, frame C3
    @(posedge clk);
    #1;
    b_r0_valid = 1'b1;
    b_r0_data  = 8'hC3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_r0_ready && n < 20);
    if (!b_r0_ready) check("timeout_b_accept", 32'd1, 32'd0);
    r0 = b_rises;
    @(posedge clk);
    #1 b_r0_valid = 1'b0;
    n = 0;
    prev_clk = b_sr_clock;
    begin
      int tog_bad;
      tog_bad = 0;
      do begin
        @(negedge clk);
        n++;
        if (n >= 2 && !b_done && b_sr_clock === prev_clk) tog_bad++;
        prev_clk = b_sr_clock;
      end while (!b_done && n < 100);
      check("b_toggle_every_cycle", tog_bad, 32'd0);
    end
    check("b_done_latency", n, 32'd19);
    check("b_rises", b_rises - r0, 32'd9);
    check("b_stage0", {24'd0, b_chain[7:0]}, 32'h000000C3);
    check("b_pad", {31'd0, b_chain[8]}, 32'd0);
    check("b_sr_oe", {31'd0, b_sr_oe}, 32'd1);

    // Final scoreboard state
    repeat (2) @(negedge clk);
    check("never_two_ready", both_cnt, 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("gid_q_drained", gid_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
